branch_cond_unit: RTL and testbench

- Parametrised successor to the ID-stage branch comparator.
- Evaluates an extended branch/conditional-move condition set on WIDTH-bit operands and registers the result through one pipeline stage with stall/flush control.
- Keeps a PC-indexed 2-bit saturating pattern history table (PHT) and reports the prediction, a mispredict flag and performance counters to the hazard/fetch logic.

---
 rtl/branch_cond_unit.sv | 160 ++++++++++++++++
 tb/tb_branch_cond_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// branch_cond_unit
// ----------------
// Evaluates branch / conditional-move conditions on WIDTH-bit operands and
// registers the outcome through one pipeline stage with stall and flush
// control. A PC-indexed table of 2-bit saturating counters supplies a
// taken/not-taken prediction for every accepted branch. A mispredict flag
// and two performance counters are reported to the hazard/fetch logic.
//
// Parameters:
//   WIDTH     operand width in bits (>= 2)
//   PHT_DEPTH number of history entries (power of 2, >= 2)
//   IDX_LSB   lowest PC bit used to index the history table
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_valid   ID stage presents an instruction with a non-zero bctrl
//   stall      hold the output stage, accept nothing
//   flush      kill the output stage and drop the current input
//   bctrl      condition select (0 none, 1-6 and 9-12 branches,
//              7/8 movz/movn, 13-15 reserved)
//   pc         PC of the presented instruction
//   d1, d2     rs / rt operands
//   cnt_clear  synchronous clear of both performance counters
//   in_ready   ~stall & ~flush
//   out_valid  registered result valid
//   cond       registered condition outcome
//   is_branch  registered: the captured code was a branch
//   pred_taken registered prediction read at accept time
//   mispredict registered branch whose outcome differs from its prediction
//   br_count   number of accepted branches (wraps)
//   mp_count   number of accepted mispredicting branches (wraps)
module branch_cond_unit #(
    parameter int WIDTH     = 32,
    parameter int PHT_DEPTH = 64,
    parameter int IDX_LSB   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       bctrl,
    input  logic [31:0]      pc,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             cnt_clear,
    output logic             in_ready,
    output logic             out_valid,
    output logic             cond,
    output logic             is_branch,
    output logic             pred_taken,
    output logic             mispredict,
    output logic [31:0]      br_count,
    output logic [31:0]      mp_count
);

    localparam int IDXW = $clog2(PHT_DEPTH);

    logic             accept;
    logic             cond_d;
    logic             branch_d;
    logic [IDXW-1:0]  pht_idx;
    logic [1:0]       pht_cur;
    logic [1:0]       pht_next;
    logic             pred_d;
    logic [1:0]       pht [PHT_DEPTH];
    logic             unused_pc_bits;

    // Only the index field of the PC matters; the remaining bits are folded
    // here so the unused upper and lower bits are acknowledged.
    assign unused_pc_bits = ^pc;

    assign in_ready = ~stall & ~flush;
    assign accept   = in_valid & ~stall & ~flush;
    assign pht_idx  = pc[IDX_LSB +: IDXW];

    // Condition evaluation. Zero tests on d1 are done as signed comparisons
    // against zero; movz/movn look only at d2. Reserved codes yield 0.
    always_comb begin
        cond_d   = 1'b0;
        branch_d = 1'b0;
        unique case (bctrl)
            4'd1: begin cond_d = (d1 == d2);                          branch_d = 1'b1; end
            4'd2: begin cond_d = (d1 != d2);                          branch_d = 1'b1; end
            4'd3: begin cond_d = ($signed(d1) <= $signed({WIDTH{1'b0}})); branch_d = 1'b1; end
            4'd4: begin cond_d = d1[WIDTH-1];                         branch_d = 1'b1; end
            4'd5: begin cond_d = ~d1[WIDTH-1];                        branch_d = 1'b1; end
            4'd6: begin cond_d = ($signed(d1) > $signed({WIDTH{1'b0}}));  branch_d = 1'b1; end
            4'd7: begin cond_d = (d2 == '0); end
            4'd8: begin cond_d = (d2 != '0); end
            4'd9: begin cond_d = (d1 < d2);                           branch_d = 1'b1; end
            4'd10: begin cond_d = (d1 >= d2);                         branch_d = 1'b1; end
            4'd11: begin cond_d = ($signed(d1) < $signed(d2));        branch_d = 1'b1; end
            4'd12: begin cond_d = ($signed(d1) >= $signed(d2));       branch_d = 1'b1; end
            default: begin cond_d = 1'b0; branch_d = 1'b0; end
        endcase
    end

    // Prediction lookup and saturating update value. The prediction is the
    // MSB of the entry before this instruction's own update is applied.
    always_comb begin
        pht_cur  = pht[pht_idx];
        pred_d   = branch_d & pht_cur[1];
        pht_next = pht_cur;
        if (cond_d) begin
            if (pht_cur != 2'b11) pht_next = pht_cur + 2'b01;
        end else begin
            if (pht_cur != 2'b00) pht_next = pht_cur - 2'b01;
        end
    end

    // History table: all entries start weakly not-taken and are written once
    // per accepted branch. Stalled or flushed cycles never touch the table.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
        end else if (accept && branch_d) begin
            pht[pht_idx] <= pht_next;
        end
    end

    // Output stage. Flush takes priority over stall; a stall freezes every
    // output register; otherwise the stage loads on accept or empties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            cond       <= 1'b0;
            is_branch  <= 1'b0;
            pred_taken <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (!stall) begin
            out_valid  <= in_valid;
            if (in_valid) begin
                cond       <= cond_d;
                is_branch  <= branch_d;
                pred_taken <= pred_d;
            end
        end
    end

    assign mispredict = out_valid & is_branch & (cond != pred_taken);

    // Performance counters advance on the accept edge of a branch; a clear
    // on the same edge wins over the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count <= 32'd0;
            mp_count <= 32'd0;
        end else if (cnt_clear) begin
            br_count <= 32'd0;
            mp_count <= 32'd0;
        end else if (accept && branch_d) begin
            br_count <= br_count + 32'd1;
            if (cond_d != pred_d) mp_count <= mp_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit
// -------------------
// Scoreboard bench for branch_cond_unit. The driver issues directed vectors
// with hand-computed condition outcomes and pushes the full expected result
// into a queue; the monitor pops and compares whenever a new result appears.
module tb_branch_cond_unit;

    typedef struct packed {
        logic        cond;
        logic        isBranch;
        logic        pred;
        logic        mp;
        logic [31:0] br;
        logic [31:0] mpc;
    } expT;

    typedef enum logic [1:0] {EDGE_ACC, EDGE_HOLD, EDGE_DROP} edgeT;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        stall;
    logic        flush;
    logic [3:0]  bctrl;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        cntClear;
    logic        inReady;
    logic        outValid;
    logic        cond;
    logic        isBranch;
    logic        predTaken;
    logic        mispredict;
    logic [31:0] brCount;
    logic [31:0] mpCount;

    expT         expQ[$];
    expT         lastExp;
    logic        lastValid;
    logic        monitorOn;
    int          checks;
    int          passes;

    logic [1:0]  phtModel [64];
    logic [31:0] brModel;
    logic [31:0] mpModel;

    branch_cond_unit dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (inValid),
        .stall      (stall),
        .flush      (flush),
        .bctrl      (bctrl),
        .pc         (pc),
        .d1         (d1),
        .d2         (d2),
        .cnt_clear  (cntClear),
        .in_ready   (inReady),
        .out_valid  (outValid),
        .cond       (cond),
        .is_branch  (isBranch),
        .pred_taken (predTaken),
        .mispredict (mispredict),
        .br_count   (brCount),
        .mp_count   (mpCount)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic codeIsBranch(input logic [3:0] code);
        return (code >= 4'd1 && code <= 4'd6) || (code >= 4'd9 && code <= 4'd12);
    endfunction

    // Drive one cycle of inputs after a falling edge. For an accepted vector
    // the bench's own history/counter model produces the expected result,
    // which is queued for the monitor.
    task automatic applyStimulus(input logic v, input logic st, input logic fl,
                                 input logic clr, input logic [3:0] code,
                                 input logic [31:0] addr, input logic [31:0] a,
                                 input logic [31:0] b, input logic expCond);
        expT        e;
        logic       br;
        logic [5:0] idx;
        @(negedge clk);
        inValid  = v;
        stall    = st;
        flush    = fl;
        cntClear = clr;
        bctrl    = code;
        pc       = addr;
        d1       = a;
        d2       = b;
        if (v && !st && !fl) begin
            br  = codeIsBranch(code);
            idx = addr[7:2];
            e.cond     = expCond;
            e.isBranch = br;
            e.pred     = br & phtModel[idx][1];
            e.mp       = br & (expCond != e.pred);
            if (br) begin
                if (expCond && phtModel[idx] != 2'b11) phtModel[idx] = phtModel[idx] + 2'b01;
                if (!expCond && phtModel[idx] != 2'b00) phtModel[idx] = phtModel[idx] - 2'b01;
                brModel = brModel + 32'd1;
                if (e.mp) mpModel = mpModel + 32'd1;
            end
            if (clr) begin
                brModel = 32'd0;
                mpModel = 32'd0;
            end
            e.br  = brModel;
            e.mpc = mpModel;
            expQ.push_back(e);
        end else if (clr) begin
            brModel = 32'd0;
            mpModel = 32'd0;
        end
        #1;
        checkOutput("in_ready", {31'd0, inReady}, {31'd0, ~st & ~fl});
    endtask

    // Monitor: classify each rising edge from the driven inputs, then compare
    // the registered outputs half a cycle later.
    initial begin
        edgeT kind;
        expT  e;
        lastValid = 1'b0;
        forever begin
            @(posedge clk);
            if (monitorOn) begin
                if (flush)       kind = EDGE_DROP;
                else if (stall)  kind = EDGE_HOLD;
                else if (inValid) kind = EDGE_ACC;
                else             kind = EDGE_DROP;
                @(negedge clk);
                case (kind)
                    EDGE_ACC: begin
                        checkOutput("out_valid", {31'd0, outValid}, 32'd1);
                        if (expQ.size() == 0) begin
                            checkOutput("scoreboard_underflow", 32'd1, 32'd0);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("cond", {31'd0, cond}, {31'd0, e.cond});
                            checkOutput("is_branch", {31'd0, isBranch}, {31'd0, e.isBranch});
                            checkOutput("pred_taken", {31'd0, predTaken}, {31'd0, e.pred});
                            checkOutput("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
                            checkOutput("br_count", brCount, e.br);
                            checkOutput("mp_count", mpCount, e.mpc);
                            lastExp   = e;
                            lastValid = 1'b1;
                        end
                    end
                    EDGE_HOLD: begin
                        checkOutput("hold_out_valid", {31'd0, outValid}, {31'd0, lastValid});
                        if (lastValid) begin
                            checkOutput("hold_cond", {31'd0, cond}, {31'd0, lastExp.cond});
                            checkOutput("hold_pred", {31'd0, predTaken}, {31'd0, lastExp.pred});
                            checkOutput("hold_br_count", brCount, lastExp.br);
                        end
                    end
                    default: begin
                        checkOutput("drop_out_valid", {31'd0, outValid}, 32'd0);
                        lastValid = 1'b0;
                    end
                endcase
            end
        end
    end

    // Directed sequence. Every history entry starts weakly not-taken (01).
    initial begin
        checks    = 0;
        passes    = 0;
        monitorOn = 1'b0;
        brModel   = 32'd0;
        mpModel   = 32'd0;
        for (int i = 0; i < 64; i++) phtModel[i] = 2'b01;
        reset    = 1'b0;
        inValid  = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        cntClear = 1'b0;
        bctrl    = 4'd0;
        pc       = 32'd0;
        d1       = 32'd0;
        d2       = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rst_cond", {31'd0, cond}, 32'd0);
        checkOutput("rst_is_branch", {31'd0, isBranch}, 32'd0);
        checkOutput("rst_pred_taken", {31'd0, predTaken}, 32'd0);
        checkOutput("rst_br_count", brCount, 32'd0);
        checkOutput("rst_mp_count", mpCount, 32'd0);
        reset     = 1'b1;
        monitorOn = 1'b1;

        // beq taken three times on one entry: 01 -> 10 -> 11 -> 11
        applyStimulus(1, 0, 0, 0, 4'd1,  32'h100, 32'h5, 32'h5, 1);
        applyStimulus(1, 0, 0, 0, 4'd1,  32'h100, 32'h5, 32'h5, 1);
        applyStimulus(1, 0, 0, 0, 4'd1,  32'h100, 32'h5, 32'h5, 1);
        // unsigned vs signed ordering, sign test of the most negative value
        applyStimulus(1, 0, 0, 0, 4'd9,  32'h104, 32'hFFFF_FFFF, 32'h1, 0);
        applyStimulus(1, 0, 0, 0, 4'd11, 32'h108, 32'hFFFF_FFFF, 32'h1, 1);
        applyStimulus(1, 0, 0, 0, 4'd5,  32'h10C, 32'h8000_0000, 32'h0, 0);
        // movz is not a branch: no history or counter change
        applyStimulus(1, 0, 0, 0, 4'd7,  32'h100, 32'h1234, 32'h0, 1);
        applyStimulus(1, 0, 0, 0, 4'd2,  32'h110, 32'h1, 32'h2, 1);
        // three stalled cycles, then one not-taken update on entry 4
        applyStimulus(1, 1, 0, 0, 4'd1,  32'h110, 32'h3, 32'h4, 0);
        applyStimulus(1, 1, 0, 0, 4'd1,  32'h110, 32'h3, 32'h4, 0);
        applyStimulus(1, 1, 0, 0, 4'd1,  32'h110, 32'h3, 32'h4, 0);
        applyStimulus(1, 0, 0, 0, 4'd1,  32'h110, 32'h3, 32'h4, 0);
        // entry 4 must be 01 here; a second taken branch then predicts taken
        applyStimulus(1, 0, 0, 0, 4'd1,  32'h110, 32'h7, 32'h7, 1);
        applyStimulus(1, 0, 0, 0, 4'd1,  32'h110, 32'h7, 32'h7, 1);
        applyStimulus(0, 0, 0, 0, 4'd0,  32'h0,   32'h0, 32'h0, 0);
        // flushes (one also stalled) must not touch history or counters
        applyStimulus(1, 1, 1, 0, 4'd1,  32'h110, 32'h9, 32'h9, 1);
        applyStimulus(1, 0, 1, 0, 4'd2,  32'h110, 32'h9, 32'h8, 1);
        applyStimulus(1, 0, 0, 0, 4'd1,  32'h110, 32'h0, 32'h1, 0);
        // clear wins over the same-edge increment
        applyStimulus(1, 0, 0, 1, 4'd3,  32'h114, 32'h0, 32'h0, 1);
        applyStimulus(1, 0, 0, 0, 4'd6,  32'h114, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 0, 0, 4'd4,  32'h118, 32'hFFFF_FFFF, 32'h0, 1);
        applyStimulus(1, 0, 0, 0, 4'd10, 32'h11C, 32'h1, 32'hFFFF_FFFF, 0);
        applyStimulus(1, 0, 0, 0, 4'd12, 32'h120, 32'h8000_0000, 32'h0, 0);
        applyStimulus(1, 0, 0, 0, 4'd8,  32'h124, 32'h0, 32'h5, 1);
        applyStimulus(1, 0, 0, 0, 4'd13, 32'h128, 32'h5, 32'h5, 0);
        applyStimulus(1, 0, 0, 0, 4'd0,  32'h12C, 32'h5, 32'h5, 0);
        applyStimulus(0, 0, 0, 0, 4'd0,  32'h0,   32'h0, 32'h0, 0);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
